// File: rtl/subleq_prog_loader.sv
// subleq_prog_loader
//   Writer side of the SUBLEQ CPU memory port. Accepts a framed byte stream
//   (MAGIC, 16-bit little-endian word count N, N*BPW data bytes LSB first,
//   optional checksum byte), assembles DATA_W-bit words and writes them to
//   consecutive word addresses starting at 0. The CPU is held while loading
//   and released once the frame completes cleanly.
//
//   Optional feature: define LOADER_CHECKSUM_EN to require a trailing byte
//   equal to the mod-256 sum of all data bytes.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse; arms the loader (restarts if already busy)
//   in_data       stream byte
//   in_valid      stream byte valid
//   in_ready      loader accepts a byte this cycle
//   mem_we        one-cycle memory write strobe
//   mem_addr      write word address
//   mem_wdata     write data
//   cpu_hold      high while the CPU must stay halted
//   done          sticky clean-completion flag, cleared by start
//   error         sticky frame-error flag, cleared by start
//   words_loaded  words written in the current frame
module subleq_prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned BPW      = DATA_W / 8;
  localparam int unsigned LANE_W   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int          MaxWords = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    StIdle,
    StSync,
    StHdrLo,
    StHdrHi,
    StData,
    StWrite,
    StCheck,
    StDone,
    StError
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e StFinish = StCheck;
`else
  localparam state_e StFinish = StDone;
`endif

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cpu_hold_q;
  logic                done_q;
  logic                error_q;
  logic [ADDR_W:0]     words_q;
  logic [15:0]         count_q;
  logic [LANE_W-1:0]   lane_q;
  logic [DATA_W-1:0]   asm_q, asm_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q;
`endif

  logic                accept;
  logic                last_lane;
  logic                last_word;
  logic [15:0]         hdr_n;

  function automatic logic is_rx(input state_e s);
    return (s == StSync) || (s == StHdrLo) || (s == StHdrHi) ||
           (s == StData) || (s == StCheck);
  endfunction

  // start takes priority over a byte offered in the same cycle.
  assign in_ready  = in_ready_q & ~start;
  assign accept    = in_valid & in_ready;
  assign last_lane = (lane_q == LANE_W'(BPW - 1));
  assign last_word = ((int'(words_q) + 1) == int'(count_q));
  assign hdr_n     = {in_data, count_q[7:0]};

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < int'(BPW); k++) begin
      if (lane_q == LANE_W'(k)) begin
        asm_d[8*k +: 8] = in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StSync;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StSync: begin
          if (accept && (in_data == MAGIC)) state_d = StHdrLo;
        end
        StHdrLo: begin
          if (accept) state_d = StHdrHi;
        end
        StHdrHi: begin
          if (accept) begin
            if (int'(hdr_n) > MaxWords) begin
              state_d = StError;
            end else if (hdr_n == 16'd0) begin
              state_d = StFinish;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (accept && last_lane) state_d = StWrite;
        end
        StWrite: state_d = last_word ? StFinish : StData;
`ifdef LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) state_d = (in_data == sum_q) ? StDone : StError;
        end
`endif
        StDone:  state_d = StIdle;
        StError: state_d = StError;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= is_rx(state_d);
      mem_we_q   <= 1'b0;
      if (start) begin
        // Restart: any partial word in asm_q is simply abandoned.
        cpu_hold_q <= 1'b1;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
        words_q    <= '0;
        addr_q     <= '0;
        lane_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_q      <= '0;
`endif
      end else begin
        unique case (state_q)
          StHdrLo: begin
            if (accept) count_q[7:0] <= in_data;
          end
          StHdrHi: begin
            if (accept) count_q[15:8] <= in_data;
          end
          StData: begin
            if (accept) begin
              asm_q <= asm_d;
`ifdef LOADER_CHECKSUM_EN
              sum_q <= sum_q + in_data;
`endif
              if (last_lane) begin
                lane_q   <= '0;
                mem_we_q <= 1'b1;
                wdata_q  <= asm_d;
              end else begin
                lane_q <= lane_q + LANE_W'(1);
              end
            end
          end
          StWrite: begin
            // Wraps to 0 after a full-capacity load; no write follows it.
            addr_q  <= addr_q + ADDR_W'(1);
            words_q <= words_q + (ADDR_W + 1)'(1);
          end
          default: ;
        endcase
        if (state_d == StDone) begin
          done_q     <= 1'b1;
          cpu_hold_q <= 1'b0;
        end
        if (state_d == StError) begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_subleq_prog_loader.sv
// tb_subleq_prog_loader
//   Randomized bench for subleq_prog_loader with a frame-level reference model:
//   every frame sent pushes its expected memory writes into a queue and a
//   single compare process matches each mem_we pulse against it.
module tb_subleq_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  subleq_prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors    = 0;
  int  miscompares = 0;
  bit  we_prev    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every write strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we) begin
      chk("we_single_cycle", 64'(we_prev), 64'd0);
      chk("hold_during_write", 64'(cpu_hold), 64'd1);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr,
                 mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", mem_wdata, e.data);
      end
    end
    we_prev = rst_n && mem_we;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  // Pulse start for one cycle, optionally offering a byte in the same cycle.
  task automatic do_start(input bit with_byte);
    @(negedge clk);
    start = 1'b1;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
    end
    #1;
    chk("ready_low_on_start", 64'(in_ready), 64'd0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_clears_flags", 64'({done, error}), 64'd0);
    chk("start_clears_words", 64'(words_loaded), 64'd0);
  endtask

  // Offer one byte after a random idle gap; returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", 64'd1, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input bit exp_done, input bit exp_err, input int words);
    int n;
    n = 0;
    while (!(done || error) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("end_reached", 64'(done || error), 64'd1);
    chk("end_done", 64'(done), 64'(exp_done));
    chk("end_error", 64'(error), 64'(exp_err));
    chk("end_hold", 64'(cpu_hold), 64'(!exp_done));
    chk("end_words", 64'(words_loaded), 64'(words));
    chk("end_pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  // Send a complete frame of n random words and check its outcome.
  task automatic run_frame(input int n, input bit bad_ck, input bit junk);
    logic [7:0]  bytes[8];
    logic [7:0]  sum;
    logic [63:0] w;
    logic [15:0] n16;
    bit          exp_err;
    do_start(1'b0);
    if (junk) begin
      send_byte(8'h00);
      send_byte(8'hFF);
    end
    n16 = 16'(n);
    send_byte(8'hA5);
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    if (n > 256) begin
      wait_end(1'b0, 1'b1, 0);
      return;
    end
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = 64'd0;
      for (int j = 0; j < 8; j++) begin
        bytes[j] = 8'($urandom);
        w        = w | (64'(bytes[j]) << (8 * j));
        sum      = sum + bytes[j];
      end
      exp_q.push_back('{addr: 8'(i), data: w});
      for (int j = 0; j < 8; j++) send_byte(bytes[j]);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_err = bad_ck;
    send_byte(bad_ck ? (sum ^ 8'h5A) : sum);
`else
    exp_err = bad_ck & 1'b0;
`endif
    wait_end(!exp_err, exp_err, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", 64'(cpu_hold), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd0);

    // Basic load with hand-computed expected words.
    do_start(1'b0);
    exp_q.push_back('{addr: 8'd0, data: 64'h0807060504030201});
    exp_q.push_back('{addr: 8'd1, data: 64'h100F0E0D0C0B0A09});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h88);
`endif
    wait_end(1'b1, 1'b0, 2);
    chk("basic_last_wdata", mem_wdata, 64'h100F0E0D0C0B0A09);
    repeat (3) @(negedge clk);
    chk("done_sticky", 64'(done), 64'd1);
    chk("done_idle_ready", 64'(in_ready), 64'd0);
    chk("done_idle_hold", 64'(cpu_hold), 64'd0);

    // Junk before MAGIC is ignored.
    run_frame(1, 1'b0, 1'b1);

    // Oversize count, then recovery.
    run_frame(257, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("error_sticky", 64'(error), 64'd1);
    chk("error_ready", 64'(in_ready), 64'd0);
    chk("error_hold", 64'(cpu_hold), 64'd1);
    run_frame(3, 1'b0, 1'b0);

    // Zero-length and full-capacity frames.
    run_frame(0, 1'b0, 1'b0);
    run_frame(256, 1'b0, 1'b0);
    chk("full_addr_wrapped", 64'(mem_addr), 64'd0);

    // Random lengths.
    for (int k = 0; k < 6; k++) run_frame(int'($urandom_range(1, 12)), 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    run_frame(1, 1'b1, 1'b0);
`endif

    // start after 3 data bytes: partial word dropped, next frame restarts at 0.
    do_start(1'b0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    do_start(1'b1);
    chk("restart_ready", 64'(in_ready), 64'd1);
    run_frame(1, 1'b0, 1'b0);

    // Reset mid-word.
    do_start(1'b0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
